// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter:
// FSM encoding, number of BCD digits and the digit adjust constant.
package bin_to_bcd_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Three digits hold any value up to 255.
    localparam int          BCD_DIGITS = 3;
    localparam logic [3:0]  BCD_ADJ    = 4'd3;

endpackage

// File: rtl/bin_to_bcd_seq_if.sv
// Handshake and result bundle between a requester and the converter.
// The master drives Start/Data_Bin; the slave (converter) drives the results.
interface bin_to_bcd_seq_if #(
    parameter int BIN_W = 8
);
    logic             Start;
    logic [BIN_W-1:0] Data_Bin;
    logic             Busy;
    logic             Done;
    logic [7:0]       Data_BCD;
    logic [3:0]       Hundreds;
    logic             Overflow;
    logic             Disp_EN;

    modport master (
        output Start, Data_Bin,
        input  Busy, Done, Data_BCD, Hundreds, Overflow, Disp_EN
    );

    modport slave (
        input  Start, Data_Bin,
        output Busy, Done, Data_BCD, Hundreds, Overflow, Disp_EN
    );
endinterface

// File: rtl/bin_to_bcd_seq_digit_adj.sv
// One double-dabble correction cell: a BCD digit of 5 or more gets +3
// so that the following left shift carries correctly into the next digit.
module bcd_digit_adj (
    input  logic [3:0] i_digit,
    output logic [3:0] o_digit
);
    import bin_to_bcd_seq_pkg::*;

    // Largest possible result is 9 + 3 = 12, so 4 bits never wrap.
    assign o_digit = (i_digit >= 4'd5) ? (i_digit + BCD_ADJ) : i_digit;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Iterative shift-add-3 binary-to-BCD converter feeding a two-digit display
// driver. One input bit is consumed per clock; results are registered on the
// edge that enters DONE and held until the next completed conversion.
module bin_to_bcd_seq #(
    parameter int BIN_W = 8,
    parameter int CNT_W = 4
) (
    input  logic            Sys_CLK,
    input  logic            Sys_RST,
    bin_to_bcd_seq_if.slave bus
);
    import bin_to_bcd_seq_pkg::*;

    localparam int ACC_W = BCD_DIGITS * 4;

    state_t             r_state;
    state_t             w_state_next;
    logic [BIN_W-1:0]   r_bin;
    logic [ACC_W-1:0]   r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic [ACC_W-1:0]   w_acc_adj;
    logic [ACC_W-1:0]   w_acc_shift;
    logic               w_last_iter;

    logic [7:0]         r_data_bcd;
    logic [3:0]         r_hundreds;
    logic               r_overflow;
    logic               r_disp_en;

    // Per-digit correction of the accumulator before each shift.
    genvar gi;
    generate
        for (gi = 0; gi < BCD_DIGITS; gi++) begin : g_digit
            bcd_digit_adj u_adj (
                .i_digit (r_acc[gi*4 +: 4]),
                .o_digit (w_acc_adj[gi*4 +: 4])
            );
        end
    endgenerate

    // Shift the corrected accumulator left, pulling in the binary MSB; the
    // top bit falls off, which never loses data for BIN_W <= 8.
    assign w_acc_shift = ACC_W'({w_acc_adj, r_bin[BIN_W-1]});
    assign w_last_iter = (r_cnt == CNT_W'(BIN_W - 1));

    // State register.
    always_ff @(posedge Sys_CLK) begin
        if (Sys_RST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: IDLE waits for Start, SHIFT runs BIN_W iterations,
    // DONE is a single-cycle result strobe.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (bus.Start) w_state_next = ST_SHIFT;
            ST_SHIFT: if (w_last_iter) w_state_next = ST_DONE;
            ST_DONE:  w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    // Datapath: load on accept, iterate in SHIFT, publish results on the
    // final iteration so outputs change only on the DONE entry edge.
    always_ff @(posedge Sys_CLK) begin
        if (Sys_RST) begin
            r_bin      <= '0;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_data_bcd <= 8'h00;
            r_hundreds <= 4'h0;
            r_overflow <= 1'b0;
            r_disp_en  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.Start) begin
                        r_bin <= bus.Data_Bin;
                        r_acc <= '0;
                        r_cnt <= '0;
                    end
                end
                ST_SHIFT: begin
                    r_bin <= r_bin << 1;
                    r_acc <= w_acc_shift;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_last_iter) begin
                        r_data_bcd <= w_acc_shift[7:0];
                        r_hundreds <= w_acc_shift[11:8];
                        r_overflow <= (w_acc_shift[11:8] != 4'h0);
                        r_disp_en  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.Busy     = (r_state == ST_SHIFT);
    assign bus.Done     = (r_state == ST_DONE);
    assign bus.Data_BCD = r_data_bcd;
    assign bus.Hundreds = r_hundreds;
    assign bus.Overflow = r_overflow;
    assign bus.Disp_EN  = r_disp_en;

endmodule
